serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 110 +++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_defs;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from two half subtractors and an OR.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d, hs1_b, hs2_b;

  always_comb begin
    hs1_d = x ^ y;
    hs1_b = ~x & y;
    d     = hs1_d ^ bin;
    hs2_b = ~hs1_d & bin;
    bout  = hs1_b | hs2_b;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first; result and final borrow published with a one-cycle done pulse.
module serial_subtractor
  import serial_sub_defs::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_shift, diff_q;
  logic [CntW-1:0]  cnt_q;
  logic             bff_q, borrow_q, busy_q, done_q;
  logic             busy_d, done_d;
  logic             fs_d, fs_bout;

  full_subtractor u_fs (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (bff_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == CntLast) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; registered below so busy/done lag the state by one edge
  always_comb begin
    busy_d = (state_q == S_SHIFT);
    done_d = (state_q == S_DONE);
  end

  // New difference bit enters at the MSB; works for WIDTH = 1 as well
  always_comb begin
    res_shift            = res_q >> 1;
    res_shift[WIDTH-1]   = fs_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bff_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            res_q <= '0;
            cnt_q <= '0;
            bff_q <= 1'b0;
          end
        end
        S_SHIFT: begin
          res_q <= res_shift;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          bff_q <= fs_bout;
          cnt_q <= cnt_q + 1'b1;
        end
        S_DONE: begin
          diff_q   <= res_q;
          borrow_q <= bff_q;
        end
        default: ;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
